// File: rtl/iomem_pwm_leds.sv
// Memory-mapped PWM LED peripheral on the picosoc iomem bus with double-buffered duty registers.
// Optional feature macro: IOMEM_PWM_IRQ_EN (CTRL.IRQ_EN bit and level period-wrap interrupt).
module iomem_pwm_leds #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned CNT_W     = 16,
    parameter logic [7:0]  BASE_ADDR = 8'h03
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic [NCH-1:0]   pwm_out,
    output logic             irq
);
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             en_q, en_d, inv_q, inv_d, irq_en_q, irq_en_d, wrap_q, wrap_d;
    logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic [7:0]       prescale_q, prescale_d, pre_q, pre_d;
    logic [CNT_W-1:0] shadow_q [NCH];
    logic [CNT_W-1:0] shadow_d [NCH];
    logic [CNT_W-1:0] active_q [NCH];
    logic [CNT_W-1:0] active_d [NCH];
    logic [NCH-1:0]   pwm_q, pwm_d;
    logic             irq_q, irq_d;

    logic        hit, wr, wrap_evt;
    logic [5:0]  idx;
    logic [31:0] rd_val, wr_val, wmask;
    logic        unused_bits;

    assign hit    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    assign wr     = hit && (iomem_wstrb != 4'b0000);
    assign idx    = iomem_addr[7:2];
    assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    // Strobed bytes replace the current register value; unstrobed bytes keep it.
    assign wr_val = (rd_val & ~wmask) | (iomem_wdata & wmask);
    assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], wr_val};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        rd_val = '0;
        case (idx)
            6'd0: rd_val[2:0]       = {irq_en_q, inv_q, en_q};
            6'd1: rd_val[CNT_W-1:0] = period_q;
            6'd2: rd_val[7:0]       = prescale_q;
            6'd3: rd_val[1:0]       = {en_q, wrap_q};
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (idx == 6'(4 + i)) rd_val[CNT_W-1:0] = shadow_q[i];
                end
            end
        endcase
    end

    always_comb begin
        ready_d    = hit;
        rdata_d    = hit ? rd_val : rdata_q;
        en_d       = en_q;
        inv_d      = inv_q;
        irq_en_d   = irq_en_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        wrap_d     = wrap_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        pre_d      = '0;
        cnt_d      = '0;
        wrap_evt   = 1'b0;

        if (en_q) begin
            if (pre_q >= prescale_q) begin
                // >= lets a PERIOD shrink below the running count wrap on the next tick.
                if (cnt_q >= period_q) wrap_evt = 1'b1;
                else                   cnt_d    = cnt_q + 1'b1;
            end else begin
                pre_d = pre_q + 8'd1;
                cnt_d = cnt_q;
            end
        end

        if (wrap_evt) begin
            wrap_d   = 1'b1;
            active_d = shadow_q;
        end

        if (wr) begin
            case (idx)
                6'd0: begin
                    en_d  = wr_val[0];
                    inv_d = wr_val[1];
`ifdef IOMEM_PWM_IRQ_EN
                    irq_en_d = wr_val[2];
`endif
                end
                6'd1: period_d   = wr_val[CNT_W-1:0];
                6'd2: prescale_d = wr_val[7:0];
                6'd3: if (iomem_wstrb[0] && iomem_wdata[0] && !wrap_evt) wrap_d = 1'b0;
                default: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (idx == 6'(4 + i)) begin
                            shadow_d[i] = wr_val[CNT_W-1:0];
                            // Stopped counter: no wrap will come, so the new duty is live at once.
                            if (!en_q) active_d[i] = wr_val[CNT_W-1:0];
                        end
                    end
                end
            endcase
        end

        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = inv_q ^ (en_q && (cnt_q < active_q[i]));
        end
        irq_d = wrap_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: the small duty arrays are plain registers, so they reset like everything else.
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            wrap_q     <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
            pre_q      <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep all state updating from the same pre-edge values.
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            inv_q      <= inv_d;
            irq_en_q   <= irq_en_d;
            wrap_q     <= wrap_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            irq_q      <= irq_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign pwm_out     = pwm_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_iomem_pwm_leds.sv
// Self-checking bench for iomem_pwm_leds: directed bus steps plus randomized PWM rounds
// checked against a time-indexed arithmetic model of counter, duty buffering and wrap flag.
module tb_iomem_pwm_leds;
    localparam int NCH = 2;
    localparam logic [7:0] BASE = 8'h03;
    localparam logic [7:0] CTRL = 8'h00, PERIOD = 8'h04, PRESC = 8'h08, STAT = 8'h0C;
    localparam logic [7:0] DUTY0 = 8'h10, DUTY1 = 8'h14;
`ifdef IOMEM_PWM_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           iomem_valid = 1'b0;
    logic           iomem_ready;
    logic [3:0]     iomem_wstrb = '0;
    logic [31:0]    iomem_addr = '0;
    logic [31:0]    iomem_wdata = '0;
    logic [31:0]    iomem_rdata;
    logic [NCH-1:0] pwm_out;
    logic           irq;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned last_hit = 0;
    int unsigned h_edge = 0;

    // Reference model state: counter position is a pure function of edges since enable.
    int per, ps, wrap_len, wm, duty_new;
    int duty_old[2];
    bit inv_m, ien_m, has_new;

    iomem_pwm_leds #(.NCH(NCH), .CNT_W(16), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rd);
        chk("ready_idle", {31'b0, iomem_ready}, 32'd0);
        iomem_addr  = {BASE, 16'($urandom), off};
        iomem_wstrb = strb;
        iomem_wdata = wd;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        last_hit = cyc;
        chk("ready_ack", {31'b0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(posedge clk); #1;
        chk("ready_drop", {31'b0, iomem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(off, 4'hF, d, r);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        bus(off, 4'h0, 32'h0, r);
        chk(tag, r, exp);
    endtask

    function automatic logic exp_pwm(int ch, int j);
        int m, c, d;
        if (j < 1) return inv_m;
        m = j - 1;
        c = (m / (ps + 1)) % (per + 1);
        d = duty_old[ch];
        if (ch == 0 && has_new && m >= (wm / wrap_len + 1) * wrap_len) d = duty_new;
        return inv_m ^ (c < d);
    endfunction

    function automatic logic exp_irq(int j);
        return IRQ_BUILD && ien_m && (j - 1 >= wrap_len);
    endfunction

    task automatic run_check(input int n);
        int j;
        repeat (n) begin
            @(negedge clk);
            j = int'(cyc - h_edge);
            for (int ch = 0; ch < NCH; ch++) chk("pwm", {31'b0, pwm_out[ch]}, {31'b0, exp_pwm(ch, j)});
            chk("irq", {31'b0, irq}, {31'b0, exp_irq(j)});
        end
    endtask

    task automatic do_round(input int p, input int s, input int d0, input int d1,
                            input bit inv, input bit ien, input int nd0, input int mid);
        wr(CTRL, 32'h0);
        wr(STAT, 32'h1);
        rd_chk("status_clear", STAT, 32'h0);
        wr(PERIOD, p);
        wr(PRESC, s);
        wr(DUTY0, d0);
        wr(DUTY1, d1);
        rd_chk("period_rb", PERIOD, p);
        rd_chk("duty1_rb", DUTY1, d1);
        per = p; ps = s; wrap_len = (p + 1) * (s + 1);
        duty_old = '{d0, d1};
        inv_m = inv; ien_m = ien; has_new = 1'b0;
        wr(CTRL, {29'b0, ien, inv, 1'b1});
        h_edge = last_hit;
        run_check(2 * wrap_len + 3);
        while (((int'(cyc - h_edge) / (ps + 1)) % (per + 1)) != mid) @(negedge clk);
        wr(DUTY0, nd0);
        wm = int'(last_hit - h_edge);
        duty_new = nd0;
        has_new = 1'b1;
        rd_chk("duty0_shadow", DUTY0, nd0);
        run_check(2 * wrap_len + 3);
        rd_chk("status_wrap", STAT, 32'h3);
        rd_chk("ctrl_rb", CTRL, {29'b0, ien & IRQ_BUILD, inv, 1'b1});
    endtask

    initial begin
        int p, s, d0, d1, nd0, mid;
        logic [31:0] r;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_pwm", {30'b0, pwm_out}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        resetn = 1'b1;

        rd_chk("rst_ctrl", CTRL, 32'h0);
        rd_chk("rst_period", PERIOD, 32'h0);
        rd_chk("rst_prescale", PRESC, 32'h0);
        rd_chk("rst_duty0", DUTY0, 32'h0);
        chk("rst_pwm_idle", {30'b0, pwm_out}, 32'd0);

        // Foreign address with valid held: never acknowledged, never written.
        iomem_addr = 32'h0400_0004; iomem_wstrb = 4'hF; iomem_wdata = 32'h1234; iomem_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("miss_ready", {31'b0, iomem_ready}, 32'd0);
        end
        iomem_valid = 1'b0; iomem_wstrb = '0;
        rd_chk("miss_no_write", PERIOD, 32'h0);

        bus(PERIOD, 4'b0001, 32'h0000_FFFF, r);
        rd_chk("strobe_lo", PERIOD, 32'h0000_00FF);
        bus(PERIOD, 4'b0010, 32'h0000_AB00, r);
        rd_chk("strobe_hi", PERIOD, 32'h0000_ABFF);
        wr(PRESC, 32'hFFFF_FF12);
        rd_chk("prescale_width", PRESC, 32'h0000_0012);
        wr(CTRL, 32'hFFFF_FFF8);
        rd_chk("ctrl_reserved", CTRL, 32'h0);
        wr(8'h40, 32'hDEAD_BEEF);
        rd_chk("unmapped", 8'h40, 32'h0);
        rd_chk("duty_oob", 8'h18, 32'h0);

        wr(CTRL, 32'h2);
        chk("inv_idle", {30'b0, pwm_out}, 32'h3);
        wr(CTRL, 32'h0);
        chk("inv_off", {30'b0, pwm_out}, 32'h0);

        do_round(9, 0, 3, 10, 1'b0, 1'b0, 7, 2);
        do_round(0, 1, 1, 0, 1'b1, 1'b1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            p   = $urandom_range(0, 7);
            s   = $urandom_range(0, 2);
            d0  = $urandom_range(0, p + 2);
            d1  = $urandom_range(0, p + 2);
            nd0 = $urandom_range(0, p + 2);
            mid = $urandom_range(0, p);
            do_round(p, s, d0, d1, 1'($urandom), 1'($urandom), nd0, mid);
        end

        // WRAP flag: set every 20 clocks, cleared by W1C except on a wrap edge.
        wr(CTRL, 32'h0);
        wr(STAT, 32'h1);
        wr(PERIOD, 32'd4);
        wr(PRESC, 32'd3);
        wr(CTRL, 32'h5);
        h_edge = last_hit;
        while (int'(cyc - h_edge) < 21) @(negedge clk);
        chk("irq_high", {31'b0, irq}, {31'b0, IRQ_BUILD});
        rd_chk("status_set", STAT, 32'h3);
        while ((int'(cyc + 1 - h_edge) % 20) != 2) @(negedge clk);
        wr(STAT, 32'h1);
        chk("irq_fall", {31'b0, irq}, 32'd0);
        rd_chk("status_w1c", STAT, 32'h2);
        while ((int'(cyc + 1 - h_edge) % 20) != 0) @(negedge clk);
        wr(STAT, 32'h1);
        rd_chk("status_w1c_vs_wrap", STAT, 32'h3);
        rd_chk("ctrl_irq_en", CTRL, IRQ_BUILD ? 32'h5 : 32'h1);
        wr(CTRL, 32'h0);
        rd_chk("status_en_off", STAT, 32'h1);

        // Reset in the middle of a running period and a pending request.
        wr(CTRL, 32'h3);
        @(negedge clk);
        iomem_addr = {BASE, 24'h0}; iomem_wstrb = '0; iomem_valid = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready", {31'b0, iomem_ready}, 32'd0);
        chk("mid_rst_rdata", iomem_rdata, 32'd0);
        chk("mid_rst_pwm", {30'b0, pwm_out}, 32'd0);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        rd_chk("post_rst_ctrl", CTRL, 32'h0);
        rd_chk("post_rst_status", STAT, 32'h0);
        rd_chk("post_rst_period", PERIOD, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
